unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: instruction fetch (FD stage) and data load/store (MW stage) of the 3-stage RISC-V core.
- Keeps at most one transaction outstanding.
- Gives data priority, with bounded starvation of fetch.
- Returns read data to the owning port through registered outputs; the pipeline derives stalls from req/gnt/rvalid.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_MAX, 4, max consecutive data grants while if_req is pending before fetch is forced to win (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch read request, held until if_gnt
if_addr  input  ADDR_W  fetch address
if_gnt  output  1  fetch request accepted by memory (1-cycle pulse)
if_rvalid  output  1  fetch read data valid (1-cycle pulse)
if_rdata  output  DATA_W  fetch read data, held until next fetch completion
d_req  input  1  data request, held until d_gnt
d_we  input  1  1=store, 0=load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_wmask  input  DATA_W/8  byte write enables
d_gnt  output  1  data request accepted (1-cycle pulse)
d_rvalid  output  1  load data valid (1-cycle pulse, loads only)
d_rdata  output  DATA_W  load data, held until next load completion
mem_req  output  1  memory request valid
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_wmask  output  DATA_W/8  memory byte mask
mem_ready  input  1  memory accepts request this cycle (mem_req & mem_ready)
mem_rvalid  input  1  memory read response valid, >=1 cycle after acceptance
mem_rdata  input  DATA_W  memory read data
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, owner=none, starve_cnt=0, every output 0 including rdata registers and latched request fields.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, arbitration:
  - If d_req and not (if_req and starve_cnt==STARVE_MAX): owner=D.
  - Else if if_req: owner=IF.
  - Else stay IDLE.
  - On a grant choice, latch addr/we/wdata/wmask of the winner (IF: we=0, wmask=0) and go to ISSUE.
- starve_cnt, updated in the IDLE choice cycle:
  - D chosen while if_req=1: increment, saturating at STARVE_MAX.
  - IF chosen, or if_req=0: clear to 0.
- ISSUE:
  - mem_req=1; mem_* driven from latched fields, stable while mem_ready=0.
  - gnt of owner = mem_ready (combinational, same cycle).
  - On acceptance: read goes to WAIT; write goes to IDLE, with no rvalid.
- WAIT:
  - mem_req=0.
  - On mem_rvalid: capture mem_rdata into owner's rdata register and go to IDLE.
  - Owner's rvalid pulses the following cycle, coinciding with the first IDLE cycle.
- Best-case read: req at cycle 0, mem_req/gnt at cycle 1, mem_rvalid at cycle 2, rvalid/rdata at cycle 3. Best-case write: gnt at cycle 1, IDLE at cycle 2.
- Requester protocol:
  - Requester deasserts req the cycle after gnt unless it issues a new request.
  - req seen in IDLE is always a new request.
  - Dropping req before gnt is ignored: the latched transaction completes normally.
- mem_rvalid in IDLE or ISSUE is ignored: no state change, no rvalid.
- Non-owner's gnt and rvalid stay 0; its rdata is unchanged.
- Reset mid-transaction: immediate return to IDLE with all outputs 0; a late mem_rvalid after reset is ignored.

Test Plan:
1. Fetch read: if_req=1, if_addr=0x100 at cycle 0, mem_ready=1, mem_rvalid with 0x00000013 at cycle 2 -> mem_addr=0x100 and if_gnt at cycle 1; if_rvalid=1, if_rdata=0x00000013 at cycle 3; d_* outputs 0 throughout.
2. Simultaneous if_req (0x104) and load d_req (0x2000) -> data issued first (mem_addr=0x2000, d_gnt); fetch issued in the next IDLE; each rvalid routed to the correct port.
3. Starvation, STARVE_MAX=4: d_req and if_req held high continuously, immediate responses -> grant order D,D,D,D,IF,D,D,D,D,IF.
4. Store d_we=1, d_wmask=0x3, d_wdata=0xDEADBEEF with mem_ready low for 3 cycles -> mem_req held with stable fields; d_gnt only on the 4th ISSUE cycle; no d_rvalid; busy falls the next cycle.
5. rst_n pulsed low while in WAIT; mem_rvalid arrives 2 cycles later -> all outputs 0, no rvalid pulse, state IDLE, rdata registers 0.
6. mem_rvalid=1 with 0x55 while IDLE with no requests -> no rvalid; if_rdata and d_rdata unchanged; busy=0.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the two core requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory environment.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_wmask;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;
  logic                  mem_ready;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rvalid, mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rvalid, mem_rdata,
    input  busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and data,
// with data priority and a bounded number of data wins while fetch waits.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  unified_mem_arbiter_if.slave bus
);
  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int MASK_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ISSUE = 2'd1, ST_WAIT = 2'd2} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_D = 2'd2} owner_t;

  state_t              state_r, state_next_s;
  owner_t              owner_r, owner_next_s;
  logic [CNT_W-1:0]    starve_cnt_r, starve_cnt_next_s;
  logic                pick_d_s, pick_if_s, accept_s, resp_s;
  logic [ADDR_W-1:0]   lat_addr_r;
  logic                lat_we_r;
  logic [DATA_W-1:0]   lat_wdata_r;
  logic [MASK_W-1:0]   lat_wmask_r;
  logic                if_rvalid_r, d_rvalid_r;
  logic [DATA_W-1:0]   if_rdata_r, d_rdata_r;

  // Arbitration and handshake qualifiers.
  always_comb begin
    pick_d_s  = bus.d_req && !(bus.if_req && (starve_cnt_r == STARVE_LIM));
    pick_if_s = !pick_d_s && bus.if_req;
    accept_s  = (state_r == ST_ISSUE) && bus.mem_ready;
    resp_s    = (state_r == ST_WAIT) && bus.mem_rvalid;
  end

  // Next state, owner and starvation counter.
  always_comb begin
    state_next_s      = state_r;
    owner_next_s      = owner_r;
    starve_cnt_next_s = starve_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_d_s) begin
          state_next_s = ST_ISSUE;
          owner_next_s = OWN_D;
        end else if (pick_if_s) begin
          state_next_s = ST_ISSUE;
          owner_next_s = OWN_IF;
        end else begin
          state_next_s = ST_IDLE;
          owner_next_s = OWN_NONE;
        end
        // Only a data win over a waiting fetch counts toward starvation.
        if (pick_d_s && bus.if_req) begin
          starve_cnt_next_s = (starve_cnt_r == STARVE_LIM) ? STARVE_LIM
                                                           : starve_cnt_r + CNT_W'(1);
        end else begin
          starve_cnt_next_s = '0;
        end
      end
      ST_ISSUE: begin
        if (accept_s) begin
          state_next_s = lat_we_r ? ST_IDLE : ST_WAIT;
          owner_next_s = lat_we_r ? OWN_NONE : owner_r;
        end else begin
          state_next_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rvalid) begin
          state_next_s = ST_IDLE;
          owner_next_s = OWN_NONE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s      = ST_IDLE;
        owner_next_s      = OWN_NONE;
        starve_cnt_next_s = '0;
      end
    endcase
  end

  // FSM state, owner and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_NONE;
      starve_cnt_r <= '0;
    end else begin
      state_r      <= state_next_s;
      owner_r      <= owner_next_s;
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Latch the winner's request so the memory sees stable fields through ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_addr_r  <= '0;
      lat_we_r    <= 1'b0;
      lat_wdata_r <= '0;
      lat_wmask_r <= '0;
    end else if (state_r == ST_IDLE && pick_d_s) begin
      lat_addr_r  <= bus.d_addr;
      lat_we_r    <= bus.d_we;
      lat_wdata_r <= bus.d_wdata;
      lat_wmask_r <= bus.d_wmask;
    end else if (state_r == ST_IDLE && pick_if_s) begin
      lat_addr_r  <= bus.if_addr;
      lat_we_r    <= 1'b0;
      lat_wdata_r <= '0;
      lat_wmask_r <= '0;
    end
  end

  // Route read responses to the owning port; rvalid lands in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_r <= 1'b0;
      d_rvalid_r  <= 1'b0;
      if_rdata_r  <= '0;
      d_rdata_r   <= '0;
    end else begin
      if_rvalid_r <= resp_s && (owner_r == OWN_IF);
      d_rvalid_r  <= resp_s && (owner_r == OWN_D);
      if (resp_s && owner_r == OWN_IF) begin
        if_rdata_r <= bus.mem_rdata;
      end
      if (resp_s && owner_r == OWN_D) begin
        d_rdata_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req   = (state_r == ST_ISSUE);
  assign bus.mem_we    = lat_we_r;
  assign bus.mem_addr  = lat_addr_r;
  assign bus.mem_wdata = lat_wdata_r;
  assign bus.mem_wmask = lat_wmask_r;
  assign bus.if_gnt    = accept_s && (owner_r == OWN_IF);
  assign bus.d_gnt     = accept_s && (owner_r == OWN_D);
  assign bus.if_rvalid = if_rvalid_r;
  assign bus.d_rvalid  = d_rvalid_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: inputs change 1ns after posedge,
// outputs are sampled on the falling edge.
module tb_unified_mem_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_ctrl: busy=%b mem_req=%b mem_addr=%h want 0", bus.busy, bus.mem_req, bus.mem_addr); end
    n_checks++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0 || bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdata: if_rdata=%h d_rdata=%h ifv=%b dv=%b want 0", bus.if_rdata, bus.d_rdata, bus.if_rvalid, bus.d_rvalid); end
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: busy=%b if_gnt=%b d_gnt=%b want 0", bus.busy, bus.if_gnt, bus.d_gnt); end
  endtask

  task automatic test_fetch_read();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h100; bus.mem_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.if_gnt !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL fetch_c0: if_gnt=%b mem_req=%b want 0", bus.if_gnt, bus.mem_req); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin
      n_fail++; $display("FAIL fetch_issue: mem_req=%b addr=%h we=%b want 1/100/0", bus.mem_req, bus.mem_addr, bus.mem_we); end
    n_checks++; if (bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fetch_gnt: if_gnt=%b d_gnt=%b want 1/0", bus.if_gnt, bus.d_gnt); end
    next_cycle();
    bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0013;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL fetch_wait: mem_req=%b busy=%b want 0/1", bus.mem_req, bus.busy); end
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h0000_0013 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL fetch_resp: if_rvalid=%b if_rdata=%h busy=%b want 1/00000013/0", bus.if_rvalid, bus.if_rdata, bus.busy); end
    n_checks++; if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL fetch_d_quiet: d_rvalid=%b d_rdata=%h d_gnt=%b want 0", bus.d_rvalid, bus.d_rdata, bus.d_gnt); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_pulse: if_rvalid=%b want 0", bus.if_rvalid); end
  endtask

  task automatic test_priority();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h104;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h2000; bus.mem_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== 32'h2000 || bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL prio_d_first: addr=%h d_gnt=%b if_gnt=%b want 2000/1/0", bus.mem_addr, bus.d_gnt, bus.if_gnt); end
    next_cycle();
    bus.d_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_0001;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hAAAA_0001 || bus.if_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL prio_d_resp: d_rvalid=%b d_rdata=%h if_rvalid=%b want 1/aaaa0001/0", bus.d_rvalid, bus.d_rdata, bus.if_rvalid); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.mem_addr !== 32'h104 || bus.if_gnt !== 1'b1 || bus.d_gnt !== 1'b0) begin
      n_fail++; $display("FAIL prio_if_second: addr=%h if_gnt=%b d_gnt=%b want 104/1/0", bus.mem_addr, bus.if_gnt, bus.d_gnt); end
    next_cycle();
    bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBBBB_0002;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hBBBB_0002 || bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL prio_if_resp: if_rvalid=%b if_rdata=%h d_rvalid=%b d_rdata=%h want 1/bbbb0002/0/aaaa0001",
                         bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata); end
  endtask

  task automatic test_starvation();
    logic [9:0] got_if;
    logic [9:0] exp_if;
    int         ngr;
    got_if = 10'b0;
    exp_if = 10'b10000_10000;
    ngr = 0;
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000;
    bus.if_req = 1'b1; bus.if_addr = 32'h400;
    bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_600D;
    for (int c = 0; c < 60 && ngr < 10; c++) begin
      @(negedge clk);
      if (bus.d_gnt === 1'b1 || bus.if_gnt === 1'b1) begin
        got_if[ngr] = bus.if_gnt;
        ngr++;
      end
      if (ngr < 10) next_cycle();
    end
    n_checks++; if (ngr != 10) begin
      n_fail++; $display("FAIL starve_count: got %0d grants want 10 within budget", ngr); end
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (got_if[i] !== exp_if[i]) begin
        n_fail++; $display("FAIL starve_order[%0d]: if_won=%b want %b", i, got_if[i], exp_if[i]); end
    end
    next_cycle();
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.if_rdata !== 32'h0000_600D) begin
      n_fail++; $display("FAIL starve_drain: busy=%b if_rdata=%h want 0/0000600d", bus.busy, bus.if_rdata); end
  endtask

  task automatic test_store_backpressure();
    next_cycle();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h3000;
    bus.d_wdata = 32'hDEAD_BEEF; bus.d_wmask = 4'h3; bus.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      n_checks++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h3000 ||
                      bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_wmask !== 4'h3 || bus.d_gnt !== 1'b0) begin
        n_fail++; $display("FAIL store_hold[%0d]: req=%b we=%b addr=%h wdata=%h mask=%h d_gnt=%b want 1/1/3000/deadbeef/3/0",
                           k, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wmask, bus.d_gnt); end
    end
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.d_gnt !== 1'b1 || bus.busy !== 1'b1 || bus.if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL store_gnt: d_gnt=%b busy=%b if_gnt=%b want 1/1/0", bus.d_gnt, bus.busy, bus.if_gnt); end
    next_cycle();
    bus.d_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL store_done: busy=%b mem_req=%b d_rvalid=%b want 0/0/0", bus.busy, bus.mem_req, bus.d_rvalid); end
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL store_no_rvalid: d_rvalid=%b want 0", bus.d_rvalid); end
  endtask

  task automatic test_reset_in_wait();
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 32'h200; bus.mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    bus.if_req = 1'b0;
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.if_gnt !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait_ctrl: busy=%b mem_req=%b addr=%h if_gnt=%b want 0", bus.busy, bus.mem_req, bus.mem_addr, bus.if_gnt); end
    n_checks++; if (bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_wait_rdata: if_rdata=%h d_rdata=%h want 0", bus.if_rdata, bus.d_rdata); end
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    next_cycle();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0077;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.if_rdata !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_rvalid: ifv=%b dv=%b if_rdata=%h busy=%b want 0", bus.if_rvalid, bus.d_rvalid, bus.if_rdata, bus.busy); end
  endtask

  task automatic run_read(input logic is_d, input logic [31:0] addr, input logic [31:0] data);
    next_cycle();
    if (is_d) begin bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = addr; end
    else      begin bus.if_req = 1'b1; bus.if_addr = addr; end
    bus.mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    bus.d_req = 1'b0; bus.if_req = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = data;
    next_cycle();
    bus.mem_rvalid = 1'b0;
  endtask

  task automatic test_idle_rvalid();
    run_read(1'b0, 32'h500, 32'hCAFE_0001);
    run_read(1'b1, 32'h5000, 32'hCAFE_0002);
    next_cycle();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_0055;
    next_cycle();
    @(negedge clk);
    n_checks++; if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_rvalid_pulse: ifv=%b dv=%b busy=%b want 0", bus.if_rvalid, bus.d_rvalid, bus.busy); end
    next_cycle();
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.if_rdata !== 32'hCAFE_0001 || bus.d_rdata !== 32'hCAFE_0002 || bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL idle_rdata_kept: if_rdata=%h d_rdata=%h ifv=%b dv=%b want cafe0001/cafe0002/0/0",
                         bus.if_rdata, bus.d_rdata, bus.if_rvalid, bus.d_rvalid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0; bus.d_wmask = 4'h0;
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    test_reset();
    test_fetch_read();
    test_priority();
    test_starvation();
    test_store_backpressure();
    test_reset_in_wait();
    test_idle_rvalid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
